conv_mac_sequencer: RTL and testbench

Initiator side of the MAC-pipe interface. It walks a valid, stride-1, no-padding 2D convolution of an R x C input by a K x K kernel. For each output position it reads operands from the input memory and the weight memory, drives one MAC pipe through an init-then-accumulate sequence, waits for the pipe to drain, and returns each result on a valid/ready output stream. It sits between the input/weight SRAMs and one MAC pipe instance in the accelerator datapath.

---
 rtl/conv_pkg.sv | 7 +
 rtl/conv_addr_gen.sv | 44 ++++
 rtl/conv_mac_sequencer.sv | 98 +++++++++
 tb/tb_conv_mac_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: FSM state encoding and MAC-pipe timing constants shared by conv_mac_sequencer
package conv_pkg;
    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, OUTPUT} state_t;
    localparam int MAC_LAT   = 2;
    localparam int MEM_LAT   = 1;
    localparam int DRAIN_CYC = MAC_LAT + MEM_LAT;
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: window/kernel counters and input/weight address arithmetic for conv_mac_sequencer
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int R = 8,
    parameter int C = 8,
    parameter int K = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     step_pair,
    input  logic                     step_window,
    output logic [$clog2(R*C)-1:0]   x_addr,
    output logic [$clog2(K*K)-1:0]   w_addr,
    output logic                     last_pair,
    output logic                     last_window
);
    localparam int CW = $clog2((R > C ? R : C) + 1);
    localparam int XAW = $clog2(R*C);
    localparam int WAW = $clog2(K*K);
    logic [CW-1:0] orow, ocol, kr, kc;
    logic kc_last, kr_last, ocol_last, orow_last;
    assign kc_last     = kc == CW'(K-1);
    assign kr_last     = kr == CW'(K-1);
    assign ocol_last   = ocol == CW'(C-K);
    assign orow_last   = orow == CW'(R-K);
    assign last_pair   = kc_last && kr_last;
    assign last_window = ocol_last && orow_last;
    assign x_addr = XAW'((32'(orow) + 32'(kr)) * C + 32'(ocol) + 32'(kc));
    assign w_addr = WAW'(32'(kr) * K + 32'(kc));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            orow <= '0;
            ocol <= '0;
            kr   <= '0;
            kc   <= '0;
        end else begin
            kc   <= step_pair ? (kc_last ? '0 : kc + 1'b1) : kc;
            kr   <= (step_pair && kc_last) ? (kr_last ? '0 : kr + 1'b1) : kr;
            ocol <= step_window ? (ocol_last ? '0 : ocol + 1'b1) : ocol;
            orow <= (step_window && ocol_last) ? (orow_last ? '0 : orow + 1'b1) : orow;
        end
    end
endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: drives one MAC pipe over a valid 2D convolution; CONV_RELU_EN clamps negative results to 0
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int R    = 8,
    parameter int C    = 8,
    parameter int K    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic signed [INW-1:0]   bias,
    output logic [$clog2(R*C)-1:0]  x_addr,
    input  logic signed [INW-1:0]   x_data,
    output logic [$clog2(K*K)-1:0]  w_addr,
    input  logic signed [INW-1:0]   w_data,
    output logic signed [INW-1:0]   mac_input0,
    output logic signed [INW-1:0]   mac_input1,
    output logic signed [INW-1:0]   mac_init_value,
    output logic                    mac_init_acc,
    output logic                    mac_input_valid,
    input  logic signed [OUTW-1:0]  mac_out,
    output logic signed [OUTW-1:0]  out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int DW = $clog2(DRAIN_CYC);
    state_t state, state_d;
    logic [DW-1:0] dcnt;
    logic issue, capture, handshake, last_pair, last_window;
    logic signed [OUTW-1:0] cap_val;

    conv_addr_gen #(.R(R), .C(C), .K(K)) u_addr (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_pair   (issue),
        .step_window (handshake),
        .x_addr      (x_addr),
        .w_addr      (w_addr),
        .last_pair   (last_pair),
        .last_window (last_window)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? INIT : IDLE;
            INIT:    state_d = last_pair ? DRAIN : ISSUE;
            ISSUE:   state_d = last_pair ? DRAIN : ISSUE;
            DRAIN:   state_d = capture ? OUTPUT : DRAIN;
            OUTPUT:  state_d = out_ready ? (last_window ? IDLE : INIT) : OUTPUT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue        = state == INIT || state == ISSUE;
        mac_init_acc = state == INIT;
        busy         = state != IDLE;
        out_valid    = state == OUTPUT;
        handshake    = out_valid && out_ready;
        capture      = state == DRAIN && dcnt == DW'(DRAIN_CYC-1);
    end

`ifdef CONV_RELU_EN
    assign cap_val = mac_out[OUTW-1] ? '0 : mac_out;
`else
    assign cap_val = mac_out;
`endif

    assign mac_input0 = x_data;
    assign mac_input1 = w_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_init_value  <= '0;
            mac_input_valid <= 1'b0;
            dcnt            <= '0;
            out_data        <= '0;
            done            <= 1'b0;
        end else begin
            mac_init_value  <= (state == IDLE && start) ? bias : mac_init_value;
            mac_input_valid <= issue;
            dcnt            <= (state == DRAIN && !capture) ? dcnt + 1'b1 : '0;
            out_data        <= capture ? cap_val : out_data;
            done            <= handshake && last_window;
        end
    end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb_conv_mac_sequencer: directed bench with a 2-cycle MAC pipe model and 4x4 input, 2x2 kernel
module tb_conv_mac_sequencer;
    localparam int INW = 16, OUTW = 64, R = 4, C = 4, K = 2, NWIN = 9;
    logic clk = 0, reset_n = 0, start = 0, out_ready = 1;
    logic signed [INW-1:0] bias = 0, x_data, w_data, mac_input0, mac_input1, mac_init_value;
    logic [3:0] x_addr;
    logic [1:0] w_addr;
    logic busy, done, mac_init_acc, mac_input_valid, out_valid;
    logic signed [OUTW-1:0] mac_out, out_data;
    logic signed [INW-1:0] x_mem [16];
    logic signed [INW-1:0] w_mem [4];
    logic signed [OUTW-1:0] p_q, acc;
    logic v_q;
    int checks = 0, errors = 0;
    logic clr = 0;
    int ninit, nvalid, ndone, vcnt;
    logic bad_win, seen_init;
    logic signed [OUTW-1:0] res [$];
    int exp_sum [NWIN] = '{10, 14, 18, 26, 30, 34, 42, 46, 50};

    always #5 clk = ~clk;

    conv_mac_sequencer #(.INW(INW), .OUTW(OUTW), .R(R), .C(C), .K(K)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .bias            (bias),
        .x_addr          (x_addr),
        .x_data          (x_data),
        .w_addr          (w_addr),
        .w_data          (w_data),
        .mac_input0      (mac_input0),
        .mac_input1      (mac_input1),
        .mac_init_value  (mac_init_value),
        .mac_init_acc    (mac_init_acc),
        .mac_input_valid (mac_input_valid),
        .mac_out         (mac_out),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always @(posedge clk) begin
        x_data <= x_mem[x_addr];
        w_data <= w_mem[w_addr];
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
            v_q <= 1'b0;
            acc <= '0;
        end else begin
            p_q <= 64'(mac_input0) * 64'(mac_input1);
            v_q <= mac_input_valid;
            acc <= mac_init_acc ? 64'(mac_init_value) : (v_q ? acc + p_q : acc);
        end
    end
    assign mac_out = acc;

    always @(posedge clk) begin
        if (clr) begin
            ninit <= 0;
            nvalid <= 0;
            ndone <= 0;
            vcnt <= 0;
            bad_win <= 1'b0;
            seen_init <= 1'b0;
            res.delete();
        end else begin
            if (out_valid && out_ready) res.push_back(out_data);
            ninit <= ninit + int'(mac_init_acc);
            nvalid <= nvalid + int'(mac_input_valid);
            ndone <= ndone + int'(done);
            if (mac_init_acc) begin
                bad_win <= bad_win | (seen_init && vcnt != K*K);
                seen_init <= 1'b1;
                vcnt <= 0;
            end else begin
                vcnt <= vcnt + int'(mac_input_valid);
            end
        end
    end

    task automatic chk(input string tag, input logic signed [OUTW-1:0] obs, input logic signed [OUTW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk) clr = 1;
        @(negedge clk) clr = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done), 1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid_seen"}, 64'(out_valid), 1);
    endtask

    task automatic check_run(input string tag, input int bias_v, input int wsign);
        logic signed [OUTW-1:0] e;
        chk({tag, "_nres"}, 64'(res.size()), NWIN);
        for (int i = 0; i < NWIN; i++) begin
            e = 64'(wsign * exp_sum[i] + bias_v);
`ifdef CONV_RELU_EN
            if (e < 0) e = '0;
`endif
            if (i < res.size()) chk($sformatf("%s_res%0d", tag, i), res[i], e);
        end
        chk({tag, "_ndone"}, 64'(ndone), 1);
        chk({tag, "_busy_after"}, 64'(busy), 0);
        chk({tag, "_ninit"}, 64'(ninit), NWIN);
        chk({tag, "_nvalid"}, 64'(nvalid), NWIN * K * K);
        chk({tag, "_win_spacing"}, 64'(bad_win), 0);
        chk({tag, "_last_win_valids"}, 64'(vcnt), K * K);
    endtask

    initial begin
        int cyc, n0, v0;
        for (int i = 0; i < 16; i++) x_mem[i] = INW'(i);
        for (int i = 0; i < 4; i++) w_mem[i] = 1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_init_acc", 64'(mac_init_acc), 0);
        chk("rst_input_valid", 64'(mac_input_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_x_addr", 64'(x_addr), 0);
        chk("rst_w_addr", 64'(w_addr), 0);
        @(negedge clk) reset_n = 1;

        clear_mon();
        pulse_start();
        wait_done("base", cyc);
        check_run("base", 0, 1);
        chk("base_cycles", 64'(cyc), 72);

        bias = 5;
        clear_mon();
        pulse_start();
        wait_done("bias5", cyc);
        check_run("bias5", 5, 1);
        bias = 0;

        clear_mon();
        out_ready = 0;
        pulse_start();
        wait_valid("bp");
        n0 = ninit;
        v0 = nvalid;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data%0d", i), out_data, 10);
            chk($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 1);
        end
        chk("bp_no_init", 64'(ninit), 64'(n0));
        chk("bp_no_valid", 64'(nvalid), 64'(v0));
        out_ready = 1;
        wait_done("bp", cyc);
        check_run("bp", 0, 1);

        clear_mon();
        pulse_start();
        @(negedge clk);
        pulse_start();
        wait_valid("ign");
        pulse_start();
        wait_done("ign", cyc);
        repeat (3) @(negedge clk);
        check_run("ign", 0, 1);

        clear_mon();
        pulse_start();
        cyc = 0;
        while (ninit < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reached_win3", 64'(ninit), 3);
        chk("mid_x_addr_live", 64'(x_addr), 3);
        #1 reset_n = 0;
        #1;
        chk("mid_busy", 64'(busy), 0);
        chk("mid_out_valid", 64'(out_valid), 0);
        chk("mid_init_acc", 64'(mac_init_acc), 0);
        chk("mid_input_valid", 64'(mac_input_valid), 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_x_addr", 64'(x_addr), 0);
        chk("mid_w_addr", 64'(w_addr), 0);
        chk("mid_done", 64'(done), 0);
        @(negedge clk) reset_n = 1;
        clear_mon();
        pulse_start();
        wait_done("after_rst", cyc);
        check_run("after_rst", 0, 1);

        for (int i = 0; i < 4; i++) w_mem[i] = -1;
        clear_mon();
        pulse_start();
        wait_done("neg", cyc);
        check_run("neg", 0, -1);
        chk("neg_cycles", 64'(cyc), 72);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
